// File: rtl/id_ex_issue.sv
// ID/EX pipeline register and ALU issue stage: decodes the ID-stage instruction,
// forwards from EX/MEM and MEM/WB, and drives operands and control to the ALU.
module id_ex_issue #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [15:0]   id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          ex_stall,
  input  logic          ex_flush,
  input  logic          exmem_wen,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_wen,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic          ex_valid,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_ctr,
  output logic          ex_slt,
  output logic          ex_beq,
  output logic          ex_memrd,
  output logic          ex_memwr,
  output logic [DW-1:0] ex_store_data,
  output logic          ex_wen,
  output logic [RW-1:0] ex_dst,
  output logic          illegal_op
);

  logic          valid_q, valid_d;
  logic [3:0]    ctr_q, ctr_d;
  logic          slt_q, slt_d;
  logic          beq_q, beq_d;
  logic          memrd_q, memrd_d;
  logic          memwr_q, memwr_d;
  logic          wr_q, wr_d;
  logic          use_imm_q, use_imm_d;
  logic [RW-1:0] dst_q, dst_d;
  logic [RW-1:0] rs_q, rs_d;
  logic [RW-1:0] rt_q, rt_d;
  logic [DW-1:0] rs_data_q, rs_data_d;
  logic [DW-1:0] rt_data_q, rt_data_d;
  logic [DW-1:0] imm_q, imm_d;
  logic          illegal_q, illegal_d;

  logic          dec_known, dec_slt, dec_beq, dec_memrd, dec_memwr;
  logic          dec_wr, dec_use_imm, dec_sext, dec_rtype;
  logic [3:0]    dec_ctr;
  logic [DW-1:0] fwd_rs, fwd_rt;

  // Older result (MEM/WB) only wins when the younger one (EX/MEM) does not match.
  function automatic logic [DW-1:0] fwd(
    input logic [RW-1:0] r,
    input logic [DW-1:0] rf,
    input logic          em_wen,
    input logic [RW-1:0] em_rd,
    input logic [DW-1:0] em_res,
    input logic          mw_wen,
    input logic [RW-1:0] mw_rd,
    input logic [DW-1:0] mw_res
  );
    if (em_wen && (em_rd != '0) && (em_rd == r))      fwd = em_res;
    else if (mw_wen && (mw_rd != '0) && (mw_rd == r)) fwd = mw_res;
    else                                               fwd = rf;
  endfunction

  always_comb begin
    dec_known   = 1'b0;
    dec_ctr     = 4'd0;
    dec_slt     = 1'b0;
    dec_beq     = 1'b0;
    dec_memrd   = 1'b0;
    dec_memwr   = 1'b0;
    dec_wr      = 1'b0;
    dec_use_imm = 1'b0;
    dec_sext    = 1'b1;
    dec_rtype   = 1'b0;
    if (id_opcode == 6'b000000) begin
      dec_rtype = 1'b1;
      dec_wr    = 1'b1;
      dec_known = 1'b1;
      case (id_funct)
        6'b100000: dec_ctr = 4'd0;
        6'b100010: dec_ctr = 4'd1;
        6'b100100: dec_ctr = 4'd2;
        6'b100101: dec_ctr = 4'd3;
        6'b101010: begin dec_ctr = 4'd1; dec_slt = 1'b1; end
        default:   begin dec_known = 1'b0; dec_wr = 1'b0; end
      endcase
    end else begin
      case (id_opcode)
        6'b001000: begin dec_known = 1'b1; dec_use_imm = 1'b1; dec_wr = 1'b1; end
        6'b001101: begin
          dec_known = 1'b1; dec_ctr = 4'd3; dec_use_imm = 1'b1;
          dec_sext = 1'b0; dec_wr = 1'b1;
        end
        6'b100011: begin
          dec_known = 1'b1; dec_use_imm = 1'b1; dec_memrd = 1'b1; dec_wr = 1'b1;
        end
        6'b101011: begin dec_known = 1'b1; dec_use_imm = 1'b1; dec_memwr = 1'b1; end
        6'b000100: begin dec_known = 1'b1; dec_ctr = 4'd1; dec_beq = 1'b1; end
        default:   dec_known = 1'b0;
      endcase
    end
  end

  // Unknown or invalid instructions become an all-zero bubble.
  always_comb begin
    valid_d   = 1'b0;
    ctr_d     = 4'd0;
    slt_d     = 1'b0;
    beq_d     = 1'b0;
    memrd_d   = 1'b0;
    memwr_d   = 1'b0;
    wr_d      = 1'b0;
    use_imm_d = 1'b0;
    dst_d     = '0;
    rs_d      = '0;
    rt_d      = '0;
    rs_data_d = '0;
    rt_data_d = '0;
    imm_d     = '0;
    illegal_d = id_valid & ~dec_known;
    if (id_valid && dec_known) begin
      valid_d   = 1'b1;
      ctr_d     = dec_ctr;
      slt_d     = dec_slt;
      beq_d     = dec_beq;
      memrd_d   = dec_memrd;
      memwr_d   = dec_memwr;
      wr_d      = dec_wr;
      use_imm_d = dec_use_imm;
      dst_d     = dec_rtype ? id_rd : id_rt;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = dec_sext ? {{(DW-16){id_imm[15]}}, id_imm} : {{(DW-16){1'b0}}, id_imm};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || ex_flush) begin
      valid_q   <= 1'b0;
      ctr_q     <= 4'd0;
      slt_q     <= 1'b0;
      beq_q     <= 1'b0;
      memrd_q   <= 1'b0;
      memwr_q   <= 1'b0;
      wr_q      <= 1'b0;
      use_imm_q <= 1'b0;
      dst_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else if (ex_stall) begin
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      ctr_q     <= ctr_d;
      slt_q     <= slt_d;
      beq_q     <= beq_d;
      memrd_q   <= memrd_d;
      memwr_q   <= memwr_d;
      wr_q      <= wr_d;
      use_imm_q <= use_imm_d;
      dst_q     <= dst_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
    end
  end

  assign fwd_rs = fwd(rs_q, rs_data_q, exmem_wen, exmem_rd, exmem_result,
                      memwb_wen, memwb_rd, memwb_result);
  assign fwd_rt = fwd(rt_q, rt_data_q, exmem_wen, exmem_rd, exmem_result,
                      memwb_wen, memwb_rd, memwb_result);

  assign ex_valid      = valid_q;
  assign alu_a         = fwd_rs;
  assign alu_b         = use_imm_q ? imm_q : fwd_rt;
  assign alu_ctr       = ctr_q;
  assign ex_slt        = slt_q;
  assign ex_beq        = beq_q;
  assign ex_memrd      = memrd_q;
  assign ex_memwr      = memwr_q;
  assign ex_store_data = fwd_rt;
  assign ex_wen        = valid_q & wr_q & (dst_q != '0);
  assign ex_dst        = dst_q;
  assign illegal_op    = illegal_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue: decode sweep, forwarding, stall/flush, illegal ops.
module tb_id_ex_issue;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [5:0]    id_opcode, id_funct;
  logic [DW-1:0] id_rs_data, id_rt_data;
  logic [15:0]   id_imm;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic          ex_stall, ex_flush;
  logic          exmem_wen, memwb_wen;
  logic [RW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_result, memwb_result;
  logic          ex_valid, ex_slt, ex_beq, ex_memrd, ex_memwr, ex_wen, illegal_op;
  logic [DW-1:0] alu_a, alu_b, ex_store_data;
  logic [3:0]    alu_ctr;
  logic [RW-1:0] ex_dst;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_issue #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_stall(ex_stall), .ex_flush(ex_flush), .exmem_wen(exmem_wen),
    .exmem_rd(exmem_rd), .exmem_result(exmem_result), .memwb_wen(memwb_wen),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result), .ex_valid(ex_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .ex_slt(ex_slt),
    .ex_beq(ex_beq), .ex_memrd(ex_memrd), .ex_memwr(ex_memwr),
    .ex_store_data(ex_store_data), .ex_wen(ex_wen), .ex_dst(ex_dst),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [5:0] op, input logic [5:0] fn,
                        input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                        input logic [RW-1:0] rd, input logic [DW-1:0] rsd,
                        input logic [DW-1:0] rtd, input logic [15:0] imm);
    id_valid = 1'b1; id_opcode = op; id_funct = fn;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
  endtask

  // Decode sweep table: opcode, funct, alu_ctr, alu_b, {slt,beq,memrd,memwr,wen}, dst
  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] ctr;
    logic [31:0] b;
    logic [4:0] flags;
    logic [4:0] dst;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{"add",  6'h00, 6'h20, 4'd0, 32'd5,        5'b00001, 5'd3};
    tbl[1] = '{"sub",  6'h00, 6'h22, 4'd1, 32'd5,        5'b00001, 5'd3};
    tbl[2] = '{"and",  6'h00, 6'h24, 4'd2, 32'd5,        5'b00001, 5'd3};
    tbl[3] = '{"or",   6'h00, 6'h25, 4'd3, 32'd5,        5'b00001, 5'd3};
    tbl[4] = '{"slt",  6'h00, 6'h2A, 4'd1, 32'd5,        5'b10001, 5'd3};
    tbl[5] = '{"addi", 6'h08, 6'h00, 4'd0, 32'hFFFFFFFC, 5'b00001, 5'd2};
    tbl[6] = '{"ori",  6'h0D, 6'h00, 4'd3, 32'h0000FFFC, 5'b00001, 5'd2};
    tbl[7] = '{"lw",   6'h23, 6'h00, 4'd0, 32'hFFFFFFFC, 5'b00101, 5'd2};
    tbl[8] = '{"sw",   6'h2B, 6'h00, 4'd0, 32'hFFFFFFFC, 5'b00010, 5'd2};
    tbl[9] = '{"beq",  6'h04, 6'h00, 4'd1, 32'd5,        5'b01000, 5'd2};

    reset = 1'b1; id_valid = 1'b0; id_opcode = '0; id_funct = '0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_rs = '0; id_rt = '0; id_rd = '0;
    ex_stall = 1'b0; ex_flush = 1'b0;
    exmem_wen = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_wen = 1'b0; memwb_rd = '0; memwb_result = '0;
    step(); step();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ctr", {28'd0, alu_ctr}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
    reset = 1'b0;

    // Asynchronous reset while a real instruction sits in EX
    set_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd7, 32'd5, 16'hFFFC);
    step();
    chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    chk("pre_rst_a", alu_a, 32'd7);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("async_rst_a", alu_a, 32'd0);
    chk("async_rst_b", alu_b, 32'd0);
    chk("async_rst_wen", {31'd0, ex_wen}, 32'd0);
    step();
    reset = 1'b0;

    foreach (tbl[i]) begin
      set_id(tbl[i].op, tbl[i].fn, 5'd1, 5'd2, 5'd3, 32'd7, 32'd5, 16'hFFFC);
      step();
      chk({tbl[i].name, "_valid"}, {31'd0, ex_valid}, 32'd1);
      chk({tbl[i].name, "_ctr"}, {28'd0, alu_ctr}, {28'd0, tbl[i].ctr});
      chk({tbl[i].name, "_a"}, alu_a, 32'd7);
      chk({tbl[i].name, "_b"}, alu_b, tbl[i].b);
      chk({tbl[i].name, "_flags"}, {27'd0, ex_slt, ex_beq, ex_memrd, ex_memwr, ex_wen},
          {27'd0, tbl[i].flags});
      chk({tbl[i].name, "_store"}, ex_store_data, 32'd5);
      if (tbl[i].flags[0]) chk({tbl[i].name, "_dst"}, {27'd0, ex_dst}, {27'd0, tbl[i].dst});
    end

    // Forwarding priority on rs, then on rt
    set_id(6'h00, 6'h20, 5'd3, 5'd2, 5'd4, 32'd7, 32'd5, 16'h0000);
    exmem_wen = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hAA;
    memwb_wen = 1'b1; memwb_rd = 5'd3; memwb_result = 32'hBB;
    step();
    chk("fwd_both_a", alu_a, 32'hAA);
    chk("fwd_both_b", alu_b, 32'd5);
    exmem_wen = 1'b0;
    #1;
    chk("fwd_memwb_a", alu_a, 32'hBB);
    memwb_rd = 5'd2;
    #1;
    chk("fwd_rt_a", alu_a, 32'd7);
    chk("fwd_rt_b", alu_b, 32'hBB);
    chk("fwd_rt_store", ex_store_data, 32'hBB);
    exmem_wen = 1'b1; exmem_rd = 5'd2;
    #1;
    chk("fwd_rt_exmem_b", alu_b, 32'hAA);
    set_id(6'h00, 6'h20, 5'd0, 5'd6, 5'd4, 32'd7, 32'd5, 16'h0000);
    exmem_rd = 5'd0; memwb_rd = 5'd0;
    step();
    chk("fwd_r0_a", alu_a, 32'd7);
    exmem_wen = 1'b0; memwb_wen = 1'b0;

    // Stall holds EX for three cycles while ID moves on; flush wins over stall
    set_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd7, 32'd5, 16'h0000);
    step();
    ex_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_id(6'h0D, 6'h00, 5'd8, 5'd9, 5'd10, 32'd99 + k, 32'd1, 16'h1234);
      step();
      chk($sformatf("stall%0d_ctr", k), {28'd0, alu_ctr}, 32'd0);
      chk($sformatf("stall%0d_a", k), alu_a, 32'd7);
      chk($sformatf("stall%0d_b", k), alu_b, 32'd5);
      chk($sformatf("stall%0d_valid", k), {31'd0, ex_valid}, 32'd1);
    end
    ex_flush = 1'b1;
    step();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_a", alu_a, 32'd0);
    chk("flush_wen", {31'd0, ex_wen}, 32'd0);
    ex_flush = 1'b0; ex_stall = 1'b0;

    // Illegal opcode: one pulse, none while stalled
    set_id(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 32'd7, 32'd5, 16'h0000);
    step();
    chk("ill_valid", {31'd0, ex_valid}, 32'd0);
    chk("ill_pulse", {31'd0, illegal_op}, 32'd1);
    chk("ill_memrd", {31'd0, ex_memrd}, 32'd0);
    ex_stall = 1'b1;
    step();
    chk("ill_stall1", {31'd0, illegal_op}, 32'd0);
    step();
    chk("ill_stall2", {31'd0, illegal_op}, 32'd0);
    id_valid = 1'b0; ex_stall = 1'b0;
    step();
    chk("ill_after", {31'd0, illegal_op}, 32'd0);
    set_id(6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 32'd7, 32'd5, 16'h0000);
    step();
    chk("ill_funct", {31'd0, illegal_op}, 32'd1);
    chk("ill_funct_valid", {31'd0, ex_valid}, 32'd0);
    id_valid = 1'b0;
    step();
    chk("ill_funct_end", {31'd0, illegal_op}, 32'd0);

    // Bubble with a valid opcode, then zero destinations
    set_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd7, 32'd5, 16'h0000);
    id_valid = 1'b0;
    step();
    chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("bubble_a", alu_a, 32'd0);
    set_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 32'd7, 32'd5, 16'h0000);
    step();
    chk("rd0_valid", {31'd0, ex_valid}, 32'd1);
    chk("rd0_wen", {31'd0, ex_wen}, 32'd0);
    set_id(6'h08, 6'h00, 5'd1, 5'd0, 5'd3, 32'd7, 32'd5, 16'h0001);
    step();
    chk("rt0_addi_wen", {31'd0, ex_wen}, 32'd0);
    chk("rt0_addi_b", alu_b, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
